// File: rtl/fc_tx_sched_pkg.sv
// fc package: link states and ordered-set words shared by the FC port blocks,
// plus the state encoding of the transmit-word scheduler (fc_tx_sched).
package fc;

   // Link state as seen by the port logic, already synchronised to the TX clock.
   typedef enum logic [3:0] {
      STATE_AC  = 4'd0,
      STATE_LR1 = 4'd1,
      STATE_LR2 = 4'd2,
      STATE_LR3 = 4'd3,
      STATE_OL1 = 4'd4,
      STATE_OL2 = 4'd5,
      STATE_OL3 = 4'd6,
      STATE_LF1 = 4'd7,
      STATE_LF2 = 4'd8
   } state_t;

   // Ordered sets, big-endian, K28.5 in the first transmitted byte.
   localparam logic [31:0] IDLE  = 32'hBC95_B5B5;
   localparam logic [31:0] R_RDY = 32'hBC95_4A4A;

   // K flags: ordered sets carry K on the first byte only, frame body words carry none.
   localparam logic [3:0] DATAK_OS   = 4'b1000;
   localparam logic [3:0] DATAK_BODY = 4'b0000;

   // Transmit scheduler FSM.
   typedef enum logic [1:0] {
      S_DOWN  = 2'd0,
      S_INIT  = 2'd1,
      S_GAP   = 2'd2,
      S_FRAME = 2'd3
   } tx_sched_state_t;

endpackage

// File: rtl/fc_tx_sched_credit_cnt.sv
// fc_credit_cnt: saturating up/down counter used to track R_RDYs still owed to the peer.
// A simultaneous inc and dec leaves the count unchanged; clr wins over both.
module fc_credit_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         inc,
   input  logic         dec,
   input  logic         clr,
   output logic [W-1:0] count
);

   // Count register: clear, saturating increment, floor-at-zero decrement.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !dec) begin
         if (count != '1) count <= count + 1'b1;
      end else if (dec && !inc) begin
         if (count != '0) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/fc_tx_sched.sv
// fc_tx_sched: per-cycle choice of frame word, IDLE or R_RDY for one FC TX port.
// Optional build macro FC_TX_SCHED_STATS_EN adds the frames_sent / rrdy_sent counters;
// without it both ports read 32'h0.
//
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   S_DOWN  | link not Active; IDLE only, source stalled
//   S_INIT  | link just went Active; sending the mandatory opening IDLEs
//   S_GAP   | between frames; fill words, R_RDYs owed, waiting for a SOF
//   S_FRAME | inside a frame; every accepted word goes straight out
module fc_tx_sched
   import fc::*;
#(
   parameter int MIN_IDLE = 6,
   parameter int MIN_GAP  = 6,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  state_t           state,
   input  logic [31:0]      avtx_data,
   input  logic             avtx_valid,
   input  logic             avtx_startofpacket,
   input  logic             avtx_endofpacket,
   output logic             avtx_ready,
   input  logic             rrdy_req,
   output logic [31:0]      tx_data,
   output logic [3:0]       tx_datak,
   output logic [CNT_W-1:0] rrdy_pending,
   output logic             err_underrun,
   output logic             err_protocol,
   output logic [31:0]      frames_sent,
   output logic [31:0]      rrdy_sent
);

   localparam int IDLE_W = $clog2(MIN_IDLE + 1);
   localparam int GAP_W  = $clog2(MIN_GAP + 1);

   // The IDLE sent on the S_DOWN -> S_INIT edge is the first of the opening run,
   // so S_INIT leaves while sending the MIN_IDLE-th one.
   localparam logic [IDLE_W-1:0] INIT_LAST = IDLE_W'(MIN_IDLE - 1);
   localparam logic [IDLE_W-1:0] INIT_ONE  = IDLE_W'(1);
   localparam logic [GAP_W-1:0]  GAP_FULL  = GAP_W'(MIN_GAP);
   localparam logic [1:0]        RUN_FULL  = 2'd2;

   tx_sched_state_t   fsm_q, fsm_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [1:0]        run_q, run_d;
   logic [IDLE_W-1:0] init_q, init_d;

   logic [31:0] data_d;
   logic [3:0]  datak_d;
   logic        send_rrdy;
   logic        set_underrun;
   logic        set_protocol;
   logic        clr_credit;

   logic             link_up;
   logic             gap_sat;
   logic             run_sat;
   logic [GAP_W-1:0] gap_fill;
   logic [1:0]       run_idle;

   assign link_up  = (state == STATE_AC);
   assign gap_sat  = (gap_q == GAP_FULL);
   assign run_sat  = (run_q == RUN_FULL);
   assign gap_fill = gap_sat ? gap_q : gap_q + 1'b1;
   assign run_idle = run_sat ? run_q : run_q + 1'b1;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) fsm_q <= S_DOWN;
      else          fsm_q <= fsm_d;
   end

   // Next state, next TX word and gap bookkeeping; avtx_ready is the only direct output.
   always_comb begin
      fsm_d        = fsm_q;
      gap_d        = gap_q;
      run_d        = run_q;
      init_d       = init_q;
      data_d       = IDLE;
      datak_d      = DATAK_OS;
      send_rrdy    = 1'b0;
      set_underrun = 1'b0;
      set_protocol = 1'b0;
      clr_credit   = 1'b0;
      avtx_ready   = 1'b0;

      unique case (fsm_q)
         S_DOWN: begin
            if (link_up) begin
               fsm_d  = S_INIT;
               init_d = INIT_ONE;
            end
         end

         S_INIT: begin
            if (init_q >= INIT_LAST) begin
               fsm_d = S_GAP;
               gap_d = GAP_FULL;
               run_d = RUN_FULL;
            end else begin
               init_d = init_q + 1'b1;
            end
         end

         S_GAP: begin
            // Owed R_RDYs hold off the next SOF until they have all gone out.
            avtx_ready = gap_sat && run_sat && (rrdy_pending == '0);
            if (avtx_valid && avtx_ready && avtx_startofpacket && !avtx_endofpacket) begin
               fsm_d  = S_FRAME;
               data_d = avtx_data;
            end else begin
               if (avtx_valid && avtx_ready) set_protocol = 1'b1;
               gap_d = gap_fill;
               if ((rrdy_pending != '0) && run_sat) begin
                  data_d    = R_RDY;
                  send_rrdy = 1'b1;
                  run_d     = 2'd0;
               end else begin
                  run_d = run_idle;
               end
            end
         end

         S_FRAME: begin
            avtx_ready = 1'b1;
            if (avtx_valid) begin
               data_d  = avtx_data;
               datak_d = (avtx_startofpacket || avtx_endofpacket) ? DATAK_OS : DATAK_BODY;
               if (avtx_endofpacket) begin
                  fsm_d = S_GAP;
                  gap_d = '0;
                  run_d = 2'd0;
               end
            end else begin
               set_underrun = 1'b1;
            end
         end

         default: ;
      endcase

      // Losing the link overrides everything: the word in flight is discarded and
      // owed credit is forgotten, since the peer will re-login anyway.
      if (!link_up && (fsm_q != S_DOWN)) begin
         fsm_d        = S_DOWN;
         data_d       = IDLE;
         datak_d      = DATAK_OS;
         send_rrdy    = 1'b0;
         set_underrun = 1'b0;
         set_protocol = (fsm_q == S_FRAME);
         clr_credit   = 1'b1;
      end
   end

   // Gap/IDLE-run/opening counters and the registered TX word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gap_q    <= '0;
         run_q    <= '0;
         init_q   <= '0;
         tx_data  <= IDLE;
         tx_datak <= DATAK_OS;
      end else begin
         gap_q    <= gap_d;
         run_q    <= run_d;
         init_q   <= init_d;
         tx_data  <= data_d;
         tx_datak <= datak_d;
      end
   end

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_underrun <= 1'b0;
         err_protocol <= 1'b0;
      end else begin
         err_underrun <= err_underrun | set_underrun;
         err_protocol <= err_protocol | set_protocol;
      end
   end

   fc_credit_cnt #(
      .W (CNT_W)
   ) u_credit (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (rrdy_req),
      .dec     (send_rrdy),
      .clr     (clr_credit),
      .count   (rrdy_pending)
   );

`ifdef FC_TX_SCHED_STATS_EN
   logic frame_done;

   assign frame_done = link_up && (fsm_q == S_FRAME) && avtx_valid && avtx_endofpacket;

   // Wrapping statistics counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frames_sent <= '0;
         rrdy_sent   <= '0;
      end else begin
         if (frame_done) frames_sent <= frames_sent + 32'd1;
         if (send_rrdy)  rrdy_sent   <= rrdy_sent + 32'd1;
      end
   end
`else
   assign frames_sent = 32'h0;
   assign rrdy_sent   = 32'h0;
`endif

endmodule

// File: tb/tb_fc_tx_sched.sv
// Bench for fc_tx_sched: directed scenarios followed by randomized traffic, every cycle
// compared against a word-level reference model of the scheduling rules.
module tb_fc_tx_sched;
   import fc::*;

   localparam int MIN_IDLE = 6;
   localparam int MIN_GAP  = 6;
   localparam int CNT_W    = 8;
   localparam int OWE_MAX  = (1 << CNT_W) - 1;
`ifdef FC_TX_SCHED_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   state_t           state;
   logic [31:0]      avtx_data;
   logic             avtx_valid;
   logic             avtx_startofpacket;
   logic             avtx_endofpacket;
   logic             avtx_ready;
   logic             rrdy_req;
   logic [31:0]      tx_data;
   logic [3:0]       tx_datak;
   logic [CNT_W-1:0] rrdy_pending;
   logic             err_underrun;
   logic             err_protocol;
   logic [31:0]      frames_sent;
   logic [31:0]      rrdy_sent;

   fc_tx_sched #(.MIN_IDLE(MIN_IDLE), .MIN_GAP(MIN_GAP), .CNT_W(CNT_W)) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .state              (state),
      .avtx_data          (avtx_data),
      .avtx_valid         (avtx_valid),
      .avtx_startofpacket (avtx_startofpacket),
      .avtx_endofpacket   (avtx_endofpacket),
      .avtx_ready         (avtx_ready),
      .rrdy_req           (rrdy_req),
      .tx_data            (tx_data),
      .tx_datak           (tx_datak),
      .rrdy_pending       (rrdy_pending),
      .err_underrun       (err_underrun),
      .err_protocol       (err_protocol),
      .frames_sent        (frames_sent),
      .rrdy_sent          (rrdy_sent)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: what the port has done, in terms of words on the wire.
   bit          m_link;     // link seen Active since last drop
   int          m_up;       // IDLEs sent since the link came up
   bit          m_fr;       // inside a frame
   int          m_fills;    // fill words since last EOF
   int          m_idles;    // IDLEs since last EOF or R_RDY
   int          m_owed;     // R_RDYs owed
   logic [31:0] m_data;
   logic [3:0]  m_k;
   bit          m_perr, m_uerr;
   int          m_frames, m_rrdys;

   task automatic m_reset();
      m_link = 0; m_up = 0; m_fr = 0; m_fills = 0; m_idles = 0; m_owed = 0;
      m_data = IDLE; m_k = 4'b1000; m_perr = 0; m_uerr = 0; m_frames = 0; m_rrdys = 0;
   endtask

   function automatic bit m_ready();
      if (!m_link || m_up < MIN_IDLE) return 1'b0;
      if (m_fr) return 1'b1;
      return (m_fills >= MIN_GAP) && (m_idles >= 2) && (m_owed == 0);
   endfunction

   function automatic int owe_add(input int o, input bit r);
      return (r && o < OWE_MAX) ? o + 1 : o;
   endfunction

   task automatic m_advance(input bit ac, input bit v, input bit s, input bit e,
                            input logic [31:0] d, input bit req, input bit acc);
      m_data = IDLE;
      m_k    = 4'b1000;
      if (!ac) begin
         if (m_link) begin
            if (m_fr) m_perr = 1;
            m_owed = 0;
         end else begin
            m_owed = owe_add(m_owed, req);
         end
         m_link = 0;
         m_fr   = 0;
      end else if (!m_link) begin
         m_link = 1; m_up = 1; m_fills = MIN_GAP; m_idles = 2;
         m_owed = owe_add(m_owed, req);
      end else if (m_up < MIN_IDLE) begin
         m_up++;
         m_owed = owe_add(m_owed, req);
      end else if (m_fr) begin
         if (v) begin
            m_data = d;
            m_k    = (s || e) ? 4'b1000 : 4'b0000;
            if (e) begin
               m_fr = 0; m_frames++; m_fills = 0; m_idles = 0;
            end
         end else begin
            m_uerr = 1;
         end
         m_owed = owe_add(m_owed, req);
      end else if (acc && s && !e) begin
         m_data = d;
         m_fr   = 1;
         m_owed = owe_add(m_owed, req);
      end else begin
         if (acc) m_perr = 1;
         m_fills++;
         if (m_owed > 0 && m_idles >= 2) begin
            m_data = R_RDY; m_rrdys++; m_idles = 0;
            m_owed = m_owed - 1 + int'(req);
         end else begin
            m_idles++;
            m_owed = owe_add(m_owed, req);
         end
      end
   endtask

   // One clock: drive at the falling edge, advance the model, compare after the rising edge.
   task automatic step(input bit ac, input bit v, input bit s, input bit e,
                       input logic [31:0] d, input bit req, output bit acc);
      state              = ac ? STATE_AC : STATE_LR1;
      avtx_valid         = v;
      avtx_startofpacket = s;
      avtx_endofpacket   = e;
      avtx_data          = d;
      rrdy_req           = req;
      acc = v && m_ready();
      chk("ready", 64'(avtx_ready), 64'(m_ready()));
      m_advance(ac, v, s, e, d, req, acc);
      @(posedge clk);
      @(negedge clk);
      chk("tx_data", 64'(tx_data), 64'(m_data));
      chk("tx_datak", 64'(tx_datak), 64'(m_k));
      chk("rrdy_pending", 64'(rrdy_pending), 64'(m_owed));
      chk("err_underrun", 64'(err_underrun), 64'(m_uerr));
      chk("err_protocol", 64'(err_protocol), 64'(m_perr));
      chk("frames_sent", 64'(frames_sent), STATS ? 64'(m_frames) : 64'd0);
      chk("rrdy_sent", 64'(rrdy_sent), STATS ? 64'(m_rrdys) : 64'd0);
   endtask

   // Hold a word valid (link Active) until it is accepted.
   task automatic offer(input logic [31:0] d, input bit s, input bit e, input bit req);
      bit acc = 0;
      for (int n = 0; n < 40 && !acc; n++) step(1, 1, s, e, d, req && n == 0, acc);
      chk("offer_accepted", 64'(acc), 64'd1);
   endtask

   // Hold a SOF until accepted, classifying the fill words sent while waiting.
   task automatic wait_sof(input logic [31:0] d, output int n_idle, output int n_rrdy,
                           output int first_rrdy);
      bit acc = 0;
      n_idle = 0; n_rrdy = 0; first_rrdy = -1;
      for (int n = 0; n < 40 && !acc; n++) begin
         step(1, 1, 1, 0, d, 0, acc);
         if (!acc) begin
            if (tx_data == R_RDY) begin
               if (first_rrdy < 0) first_rrdy = n_idle + n_rrdy;
               n_rrdy++;
            end else if (tx_data == IDLE) begin
               n_idle++;
            end
         end
      end
      chk("sof_accepted", 64'(acc), 64'd1);
      chk("sof_on_wire", 64'(tx_data), 64'(d));
      chk("sof_datak", 64'(tx_datak), 64'h8);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_tx_data"}, 64'(tx_data), 64'(IDLE));
      chk({tag, "_tx_datak"}, 64'(tx_datak), 64'h8);
      chk({tag, "_ready"}, 64'(avtx_ready), 64'd0);
      chk({tag, "_pending"}, 64'(rrdy_pending), 64'd0);
      chk({tag, "_errs"}, 64'({err_underrun, err_protocol}), 64'd0);
      chk({tag, "_counters"}, 64'({frames_sent, rrdy_sent}), 64'd0);
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int ni, nr, rp;
      bit acc, ac, v, s, e, req, bad;
      int pos, len;
      logic [31:0] cur;

      state = STATE_AC; avtx_data = '0; avtx_valid = 1; avtx_startofpacket = 1;
      avtx_endofpacket = 0; rrdy_req = 0;
      m_reset();
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      reset_n = 1;

      // 1: opening IDLE run after release, then SOF
      wait_sof(32'h1100_0001, ni, nr, rp);
      chk("t1_idles", 64'(ni), 64'(MIN_IDLE));
      chk("t1_rrdys", 64'(nr), 64'd0);
      offer(32'h1100_0002, 0, 0, 0);
      offer(32'h1100_0003, 0, 0, 0);
      offer(32'h1100_0004, 0, 1, 0);

      // 2: back-to-back frame, minimum gap
      wait_sof(32'h2200_0001, ni, nr, rp);
      chk("t2_gap_idles", 64'(ni), 64'(MIN_GAP));
      offer(32'h2200_0002, 0, 0, 0);
      offer(32'h2200_0003, 0, 0, 0);
      offer(32'h2200_0004, 0, 1, 0);
      chk("t2_frames", 64'(frames_sent), STATS ? 64'd2 : 64'd0);

      // 3: three credit returns right after EOF
      for (int i = 0; i < 9; i++) begin
         step(1, 0, 0, 0, 32'h0, i < 3, acc);
         chk("t3_seq", 64'(tx_data), (i % 3 == 2) ? 64'(R_RDY) : 64'(IDLE));
      end
      chk("t3_pending", 64'(rrdy_pending), 64'd0);
      chk("t3_rrdy_sent", 64'(rrdy_sent), STATS ? 64'd3 : 64'd0);

      // 4: credit owed inside a frame goes out in the following gap
      offer(32'h4400_0001, 1, 0, 0);
      offer(32'h4400_0002, 0, 0, 0);
      offer(32'h4400_0003, 0, 0, 1);
      offer(32'h4400_0004, 0, 1, 0);
      chk("t4_pending", 64'(rrdy_pending), 64'd1);
      wait_sof(32'h5500_0001, ni, nr, rp);
      chk("t4_fills", 64'(ni + nr), 64'(MIN_GAP));
      chk("t4_rrdy_pos", 64'(rp), 64'd2);

      // 5: one-cycle underrun inside the frame
      offer(32'h5500_0002, 0, 0, 0);
      step(1, 0, 0, 0, 32'h0, 0, acc);
      chk("t5_idle_in_frame", 64'(tx_data), 64'(IDLE));
      chk("t5_underrun", 64'(err_underrun), 64'd1);
      offer(32'h5500_0003, 0, 0, 0);
      offer(32'h5500_0004, 0, 1, 0);
      chk("t5_frames", 64'(frames_sent), STATS ? 64'd4 : 64'd0);

      // 6: link drops mid-frame with credit owed, then async reset mid-cycle
      wait_sof(32'h6600_0001, ni, nr, rp);
      for (int i = 0; i < 5; i++) offer(32'h6600_0010 + 32'(i), 0, 0, 1);
      chk("t6_pending5", 64'(rrdy_pending), 64'd5);
      step(0, 1, 0, 0, 32'h6600_00FF, 0, acc);
      chk("t6_idle", 64'(tx_data), 64'(IDLE));
      chk("t6_ready", 64'(avtx_ready), 64'd0);
      chk("t6_pending0", 64'(rrdy_pending), 64'd0);
      chk("t6_protocol", 64'(err_protocol), 64'd1);
      #2 reset_n = 0;
      #1 check_reset_values("t6_async");
      m_reset();
      @(negedge clk);
      reset_n = 1;

      // pending counter saturation while the link is down, then cleared on a drop
      for (int i = 0; i < OWE_MAX + 5; i++) step(0, 0, 0, 0, 32'h0, 1, acc);
      chk("sat_pending", 64'(rrdy_pending), 64'(OWE_MAX));
      step(1, 0, 0, 0, 32'h0, 0, acc);
      step(0, 0, 0, 0, 32'h0, 0, acc);
      chk("sat_cleared", 64'(rrdy_pending), 64'd0);

      // randomized traffic
      pos = 0; len = 4; cur = $urandom;
      for (int c = 0; c < 4000; c++) begin
         ac  = ($urandom_range(0, 299) != 0);
         v   = ($urandom_range(0, 15) != 0);
         s   = (pos == 0);
         e   = (pos == len - 1);
         bad = (pos == 0) && ($urandom_range(0, 29) == 0);
         if (bad) begin
            if ($urandom_range(0, 1) == 0) s = 0;
            else e = 1;
         end
         req = ($urandom_range(0, 11) == 0);
         step(ac, v, s, e, cur, req, acc);
         if (acc) begin
            cur = $urandom;
            if (!bad) begin
               if (pos == len - 1) begin
                  pos = 0;
                  len = $urandom_range(2, 7);
               end else begin
                  pos++;
               end
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
